sao_band_offset_estimator: RTL and testbench

Encoder-side counterpart of the SAO band-offset filter. It streams co-located original and reconstructed (deblocked) 8-bit pixels for one block and accumulates per-band error statistics over the 32 HEVC bands (pixel >> 3). It then selects the best 4-band window and emits the band position plus four clamped, rounded offsets for the SAO band-offset stage to apply.

---
 rtl/sao_band_offset_estimator.sv | 192 +++++++++++++++++++
 tb/tb_sao_band_offset_estimator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sao_band_offset_estimator.sv
`default_nettype none
// sao_band_offset_estimator -- per-band SAO error statistics, best 4-band window search
// and rounded, clamped band offsets for one block of pixels (rev 1.0)
module sao_band_offset_estimator #(
  parameter int BLK_PIXELS = 4096,
  parameter int MAX_OFFSET = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_orig,
  input  logic [7:0] in_recon,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_band_pos,
  output logic [3:0] out_offset0,
  output logic [3:0] out_offset1,
  output logic [3:0] out_offset2,
  output logic [3:0] out_offset3,
  output logic       out_enable
);
  localparam int CNT_W = $clog2(BLK_PIXELS);
  localparam int SUM_W = 10 + CNT_W;
  localparam int WIN_W = SUM_W + 2;
  localparam int REM_W = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(BLK_PIXELS - 1);
  localparam logic [CNT_W-1:0] PIX_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   CNT_ONE   = (CNT_W + 1)'(1);
  localparam logic [3:0]       OFF_LIMIT = 4'(MAX_OFFSET);

  typedef enum logic [2:0] {ACCUM, SCAN, DIV, OUT, CLEAR} state_t;
  state_t state;

  logic signed [SUM_W-1:0] sum_q [32];
  logic [CNT_W:0]          cnt_q [32];
  logic [CNT_W-1:0]        pix_cnt;
  logic [4:0]              scan_pos;
  logic [4:0]              best_pos;
  logic [WIN_W-1:0]        best_w;
  logic [1:0]              div_band;
  logic [2:0]              div_step;
  logic [REM_W-1:0]        rem;
  logic [CNT_W:0]          div_cnt;
  logic                    div_neg;
  logic [3:0]              quo;
  logic [3:0]              off0, off1, off2;

  function automatic logic [SUM_W-1:0] mag(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-1:0] r;
    r = v[SUM_W-1] ? -v : v;
    return r;
  endfunction

  logic             accept;
  logic [4:0]       band;
  logic signed [8:0] diff;
  logic [4:0]       scan_p1, scan_p2, scan_p3;
  logic [WIN_W-1:0] win;
  logic [4:0]       div_idx;
  logic             div_take;
  logic [3:0]       quo_fin;
  logic [3:0]       off_fin;

  assign accept  = in_valid && in_ready;
  assign band    = in_recon[7:3];
  assign diff    = $signed({1'b0, in_orig}) - $signed({1'b0, in_recon});
  assign scan_p1 = scan_pos + 5'd1;
  assign scan_p2 = scan_pos + 5'd2;
  assign scan_p3 = scan_pos + 5'd3;
  assign win     = WIN_W'(mag(sum_q[scan_pos])) + WIN_W'(mag(sum_q[scan_p1]))
                 + WIN_W'(mag(sum_q[scan_p2])) + WIN_W'(mag(sum_q[scan_p3]));
  assign div_idx = best_pos + {3'b000, div_band};
  // Step 0 only loads the divider, so its stale remainder must not count as a step.
  assign div_take = (div_step != 3'd0) && (div_cnt != '0) &&
                    (rem >= REM_W'(div_cnt)) && (quo < OFF_LIMIT);
  assign quo_fin = quo + (div_take ? 4'd1 : 4'd0);
  assign off_fin = div_neg ? (4'd0 - quo_fin) : quo_fin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCUM;
      in_ready     <= 1'b0;
      pix_cnt      <= '0;
      scan_pos     <= '0;
      best_pos     <= '0;
      best_w       <= '0;
      div_band     <= '0;
      div_step     <= '0;
      rem          <= '0;
      div_cnt      <= '0;
      div_neg      <= 1'b0;
      quo          <= '0;
      off0         <= '0;
      off1         <= '0;
      off2         <= '0;
      out_valid    <= 1'b0;
      out_band_pos <= '0;
      out_offset0  <= '0;
      out_offset1  <= '0;
      out_offset2  <= '0;
      out_offset3  <= '0;
      out_enable   <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            sum_q[band] <= sum_q[band] + {{(SUM_W-9){diff[8]}}, diff};
            cnt_q[band] <= cnt_q[band] + CNT_ONE;
            if (pix_cnt == LAST_PIX) begin
              pix_cnt  <= '0;
              in_ready <= 1'b0;
              state    <= SCAN;
            end else begin
              pix_cnt <= pix_cnt + PIX_ONE;
            end
          end
        end
        SCAN: begin
          if (win > best_w) begin
            best_w   <= win;
            best_pos <= scan_pos;
          end
          if (scan_pos == 5'd28) begin
            scan_pos <= '0;
            div_band <= '0;
            div_step <= '0;
            state    <= DIV;
          end else begin
            scan_pos <= scan_p1;
          end
        end
        DIV: begin
          if (div_step == 3'd0) begin
            // Adding C/2 before dividing turns truncation into round-half-up.
            rem     <= REM_W'(mag(sum_q[div_idx])) + REM_W'(cnt_q[div_idx] >> 1);
            div_cnt <= cnt_q[div_idx];
            div_neg <= sum_q[div_idx][SUM_W-1];
            quo     <= '0;
          end else if (div_take) begin
            rem <= rem - REM_W'(div_cnt);
            quo <= quo + 4'd1;
          end
          div_step <= div_step + 3'd1;
          if (div_step == 3'd7) begin
            div_band <= div_band + 2'd1;
            case (div_band)
              2'd0: off0 <= off_fin;
              2'd1: off1 <= off_fin;
              2'd2: off2 <= off_fin;
              default: begin
                out_band_pos <= best_pos;
                out_offset0  <= off0;
                out_offset1  <= off1;
                out_offset2  <= off2;
                out_offset3  <= off_fin;
                out_enable   <= |{off0, off1, off2, off_fin};
                out_valid    <= 1'b1;
                state        <= OUT;
              end
            endcase
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          for (int i = 0; i < 32; i++) begin
            sum_q[i] <= '0;
            cnt_q[i] <= '0;
          end
          pix_cnt  <= '0;
          scan_pos <= '0;
          best_pos <= '0;
          best_w   <= '0;
          in_ready <= 1'b1;
          state    <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sao_band_offset_estimator.sv
`default_nettype none
// tb_sao_band_offset_estimator -- directed pixel blocks checked against a per-block
// reference model plus literal expectations (rev 1.0)
module tb_sao_band_offset_estimator;
  localparam int BLK  = 16;
  localparam int MAXO = 7;
  localparam int LAT  = 62;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_orig;
  logic [7:0] in_recon;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_band_pos;
  logic [3:0] out_offset0, out_offset1, out_offset2, out_offset3;
  logic       out_enable;

  sao_band_offset_estimator #(.BLK_PIXELS(BLK), .MAX_OFFSET(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_orig(in_orig), .in_recon(in_recon),
    .out_valid(out_valid), .out_ready(out_ready), .out_band_pos(out_band_pos),
    .out_offset0(out_offset0), .out_offset1(out_offset1),
    .out_offset2(out_offset2), .out_offset3(out_offset3), .out_enable(out_enable)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] o; logic [7:0] r; } pix_t;
  typedef struct packed {
    logic [4:0] pos;
    logic [3:0] o0, o1, o2, o3;
    logic       en;
    int         L;
  } exp_t;

  pix_t pix_q[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   hs_edge = -10;
  bit   prev_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] blk_o [16];
  logic [7:0] blk_r [16];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain per-band sums, exhaustive window search, integer rounded division.
  function automatic exp_t model_block(input int L);
    int s [32];
    int c [32];
    int best_w, pos, w, q, sv, cv, b, v;
    logic [3:0] off [4];
    exp_t e;
    for (int k = 0; k < 32; k++) begin s[k] = 0; c[k] = 0; end
    foreach (pix_q[i]) begin
      b = int'(pix_q[i].r) / 8;
      s[b] += int'(pix_q[i].o) - int'(pix_q[i].r);
      c[b] += 1;
    end
    best_w = 0; pos = 0;
    for (int p = 0; p <= 28; p++) begin
      w = iabs(s[p]) + iabs(s[p+1]) + iabs(s[p+2]) + iabs(s[p+3]);
      if (w > best_w) begin best_w = w; pos = p; end
    end
    for (int k = 0; k < 4; k++) begin
      sv = s[pos+k]; cv = c[pos+k];
      q = (cv == 0) ? 0 : (iabs(sv) + cv / 2) / cv;
      if (q > MAXO) q = MAXO;
      v = (sv < 0) ? -q : q;
      off[k] = 4'(v);
    end
    e.pos = 5'(pos);
    e.o0 = off[0]; e.o1 = off[1]; e.o2 = off[2]; e.o3 = off[3];
    e.en = (off[0] != 0) || (off[1] != 0) || (off[2] != 0) || (off[3] != 0);
    e.L = L;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Captures accepted pixels and retires parameter sets on handshake.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs_edge <= cyc;
      end
      if (in_valid && in_ready) begin
        pix_q.push_back({in_orig, in_recon});
        if (pix_q.size() == BLK) begin
          exp_q.push_back(model_block(cyc));
          pix_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("band_pos", out_band_pos, exp_q[0].pos);
          check("offset0", out_offset0, exp_q[0].o0);
          check("offset1", out_offset1, exp_q[0].o1);
          check("offset2", out_offset2, exp_q[0].o2);
          check("offset3", out_offset3, exp_q[0].o3);
          check("enable", out_enable, exp_q[0].en);
          if (!prev_valid) check("latency", cyc - exp_q[0].L, LAT);
        end
        check("in_ready_during_out", in_ready, 0);
      end
      if (cyc == hs_edge + 1) begin
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_clear_cycle", in_ready, 0);
      end
      if (cyc == hs_edge + 2) check("in_ready_after_hs", in_ready, 1);
    end
    prev_valid = out_valid;
  end

  task automatic send_pixels(input int n, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_orig = blk_o[i]; in_recon = blk_r[i];
      while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
      if (guard >= 300) check("accept_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int pos, input int o0, input int o1,
                            input int o2, input int o3, input int en);
    int g;
    g = 0;
    while (!out_valid && g < 200) begin @(negedge clk); g++; end
    if (!out_valid) begin
      check({tag, "_out_valid_timeout"}, 0, 1);
    end else begin
      check({tag, "_pos"}, out_band_pos, pos);
      check({tag, "_off0"}, out_offset0, o0);
      check({tag, "_off1"}, out_offset1, o1);
      check({tag, "_off2"}, out_offset2, o2);
      check({tag, "_off3"}, out_offset3, o3);
      check({tag, "_en"}, out_enable, en);
    end
  endtask

  initial begin
    logic [20:0] snap;
    int d;
    reset_n = 1'b0; in_valid = 1'b0; in_orig = '0; in_recon = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_band_pos", out_band_pos, 0);
    check("rst_offsets", {out_offset0, out_offset1, out_offset2, out_offset3}, 0);
    check("rst_enable", out_enable, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // A: no error anywhere
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'(i * 16 + 5); blk_o[i] = blk_r[i]; end
    send_pixels(16, 1'b0);
    expect_out("A", 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // B: band 16 only, +2 each
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'd130; blk_o[i] = 8'd132; end
    send_pixels(16, 1'b0);
    expect_out("B", 13, 0, 0, 0, 2, 1);
    repeat (3) @(negedge clk);

    // C: band 5, +20 each, clamped; input gaps
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'd40; blk_o[i] = 8'd60; end
    send_pixels(16, 1'b1);
    expect_out("C", 2, 0, 0, 0, 7, 1);
    repeat (3) @(negedge clk);

    // D: band 8 S=-3 C=2 rounds half-up to -2
    blk_r[0] = 8'd64; blk_o[0] = 8'd63;
    blk_r[1] = 8'd65; blk_o[1] = 8'd63;
    for (int i = 2; i < 16; i++) begin blk_r[i] = 8'(72 + (i % 8)); blk_o[i] = blk_r[i]; end
    send_pixels(16, 1'b0);
    expect_out("D", 5, 0, 0, 0, 14, 1);
    repeat (3) @(negedge clk);

    // E: mixed signs over bands 10..13, held under backpressure
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: d = 5;
        1: d = -3;
        2: d = 1;
        default: d = -6;
      endcase
      blk_r[i] = 8'(82 + (i % 4) * 8);
      blk_o[i] = 8'(int'(blk_r[i]) + d);
    end
    out_ready = 1'b0;
    send_pixels(16, 1'b0);
    expect_out("E", 10, 5, 13, 1, 10, 1);
    snap = {out_band_pos, out_offset0, out_offset1, out_offset2, out_offset3};
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'd200; blk_o[i] = 8'd199; end
    in_valid = 1'b1; in_orig = blk_o[0]; in_recon = blk_r[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", {out_band_pos, out_offset0, out_offset1, out_offset2, out_offset3}, snap);
      check("bp_out_valid", out_valid, 1);
      check("bp_no_accept", pix_q.size(), 0);
    end
    out_ready = 1'b1;

    // F: band 25, -1 each; must not see E's statistics
    send_pixels(16, 1'b0);
    expect_out("F", 22, 0, 0, 0, 15, 1);
    repeat (3) @(negedge clk);

    // G: aborted by reset after 7 pixels
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'd168; blk_o[i] = 8'd190; end
    send_pixels(7, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);

    // H: band 3, +3 each, post-reset pixels only
    for (int i = 0; i < 16; i++) begin blk_r[i] = 8'd24; blk_o[i] = 8'd27; end
    send_pixels(16, 1'b0);
    expect_out("H", 0, 0, 0, 0, 3, 1);
    repeat (5) @(negedge clk);
    check("all_sets_retired", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
